fifo_wptr_full: RTL
===================

# fifo_wptr_full

Write-side pointer and full-flag generator for the async FIFO; source end of the read-pointer synchronizer crossing. Accepts push requests in the write domain and produces the RAM write enable and address. Publishes a registered, Gray-coded write pointer for the read domain's 2-flop synchronizer to sample. Computes `full` (and optionally `afull`) against the read pointer after it has been synchronized into this domain.

## Interface
- `ADDR_W`, default 4: RAM address width; FIFO depth = 2^ADDR_W.
- `AFULL_LEVEL`, default 12: occupancy at or above which `afull` asserts; legal range 1..2^ADDR_W.
- `clk`  in  1  write-domain clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `push`  in  1  write request; data is valid on the RAM data bus this cycle.
- `rptr_gray_sync`  in  ADDR_W+1  read pointer, Gray-coded, already synchronized into `clk` domain.
- `wen`  out  1  RAM write enable (combinational): `push & ~full`.
- `waddr`  out  ADDR_W  RAM write address = `wbin[ADDR_W-1:0]` (registered).
- `wptr_gray`  out  ADDR_W+1  Gray write pointer, driven directly from a flop; goes to the read-domain synchronizer.
- `full`  out  1  FIFO full (registered).
- `afull`  out  1  almost full (registered); constant 0 when the feature is compiled out.
- `overflow`  out  1  sticky: set when `push` is asserted while `full`; cleared only by reset.

## Operation
- State: `wbin` (ADDR_W+1 bits), `wptr_gray`, `full`, `overflow`, and `afull` when enabled.
- Every cycle:
  - `wbin_next = wbin + wen`, modulo 2^(ADDR_W+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- Full test:
  - `full_next = (wgray_next == {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]})`.
  - The test is evaluated every cycle, not only on pushes, so `full` also clears when the read pointer advances.
- Push while full:
  - `wen` = 0; `wbin` and `wptr_gray` hold.
  - `overflow` sets on that edge; the push is dropped.
- Wrap: `wbin` rolls from 2^(ADDR_W+1)−1 to 0 with no special handling. The extra MSB distinguishes full from empty.
- Gray integrity: `wptr_gray` changes by exactly one bit per accepted push and holds otherwise. No combinational path may reach the `wptr_gray` port.
- Simultaneous push and read-pointer change in the same cycle: both feed `full_next`. The result is whatever the equation gives, with no priority logic.
- Reset mid-operation: all state returns to reset values on the next edge; `wen` is gated by `full` only, not by reset.
- Reset values: `wbin` 0, `waddr` 0, `wptr_gray` 0, `full` 0, `afull` 0, `overflow` 0. `wen` is 0 whenever `push` is 0.

## Timing
- `waddr`, `wptr_gray`, `full`, and `afull` all update on the same `clk` edge that consumes the push.
- The push that fills the FIFO sees `full` = 1 on the following cycle. The next push is blocked combinationally through `wen`.
- `full` deasserts one `clk` cycle after `rptr_gray_sync` changes. The end-to-end release latency (read side) is therefore the 2-flop synchronizer plus 1 cycle; this is conservative by design.
- `wen` has zero latency from `push` and `full`.

## Configuration
- `FIFO_WPTR_AFULL_EN` defined:
  - Instantiates a Gray-to-binary converter on `rptr_gray_sync` giving `rbin`.
  - Computes `level_next = wbin_next - rbin` (ADDR_W+1 bits, modulo).
  - Registers `afull <= (level_next >= AFULL_LEVEL)`, with the same update and release timing as `full`.
- `FIFO_WPTR_AFULL_EN` undefined: the converter, subtractor and `afull` flop are absent, and `afull` is tied to 0.

## Test plan
- Reset check: hold `rst_n` = 0 for 3 cycles with `push` = 1 -> all outputs 0. `wen` still follows `push & ~full`, so it reads 1, but nothing registers.
- Fill (`ADDR_W`=4), `rptr_gray_sync` = 0: 16 consecutive pushes -> `full` = 1 the cycle after the 16th push; `wptr_gray` = 5'b11000; `waddr` = 0.
- Overflow: 17th push while `full` -> `wen` = 0; `wptr_gray` holds 5'b11000; `overflow` = 1 next cycle and stays 1 after `push` drops.
- Release: from full, set `rptr_gray_sync` = 5'b00001 -> `full` = 0 one cycle later; one further push -> `full` = 1 again, `wptr_gray` = 5'b11001.
- Wrap and Gray check: 64 pushes with `rptr_gray_sync` tracking `wptr_gray` after 2 cycles -> `wbin` wraps twice; every `wptr_gray` transition has Hamming distance exactly 1; `full` is never asserted.
- With `FIFO_WPTR_AFULL_EN` and `AFULL_LEVEL` = 12, rptr 0: `afull` = 1 the cycle after the 12th push and `full` = 0. Advance rptr to Gray(2) -> `afull` = 0 one cycle later.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer / full-flag generator for the async FIFO; publishes a flopped Gray write pointer.
// Define FIFO_WPTR_AFULL_EN to build the almost-full flag (otherwise afull is tied to 0).
module fifo_wptr_full #(
   parameter int ADDR_W      = 4,
   parameter int AFULL_LEVEL = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [ADDR_W:0]   rptr_gray_sync,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   wptr_gray,
   output logic              full,
   output logic              afull,
   output logic              overflow
);

   localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_LEVEL);

   logic [ADDR_W:0] wbin, wbin_next, wgray_next, rptr_full_cmp;
   logic            full_next;

   assign wen        = push & ~full;
   assign wbin_next  = wbin + {{ADDR_W{1'b0}}, wen};
   assign wgray_next = wbin_next ^ (wbin_next >> 1);
   assign waddr      = wbin[ADDR_W-1:0];

   // Full when the write pointer is exactly one lap ahead: Gray form inverts the top two bits.
   assign rptr_full_cmp = {~rptr_gray_sync[ADDR_W:ADDR_W-1], rptr_gray_sync[ADDR_W-2:0]};
   assign full_next     = (wgray_next == rptr_full_cmp);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wbin      <= '0;
         wptr_gray <= '0;
         full      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         wbin      <= wbin_next;
         wptr_gray <= wgray_next;
         full      <= full_next;
         overflow  <= overflow | (push & full);
      end
   end

`ifdef FIFO_WPTR_AFULL_EN
   logic [ADDR_W:0] rbin, level_next;
   logic            afull_next;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= ADDR_W; i++)
         rbin[i] = ^(rptr_gray_sync >> i);
   end

   assign level_next = wbin_next - rbin;
   assign afull_next = (level_next >= AFULL_LVL);

   always_ff @(posedge clk) begin
      if (!rst_n) afull <= 1'b0;
      else        afull <= afull_next;
   end
`else
   logic unused_afull_lvl;
   assign unused_afull_lvl = ^AFULL_LVL;
   assign afull            = 1'b0;
`endif

endmodule
